// File: rtl/mem_arbiter.sv
// Memory arbiter for the instruction-fetch and load/store requesters. It grants one request per cycle and caps in-flight reads per requester.
// Fixed priority (D over IF) by default; define MEM_ARB_RR_EN for round-robin arbitration.

package params_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_size_t;
endpackage

module mem_arbiter
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH      = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = params_pkg::DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_valid_i,
    output logic                  if_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] if_rsp_data_o,

    input  logic                  d_req_valid_i,
    output logic                  d_req_ready_o,
    input  logic                  d_req_wr_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wr_data_i,
    input  access_size_t          d_access_size_i,
    output logic                  d_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] d_rsp_data_o,

    output logic                  mem_rd_req_valid_o,
    output logic                  mem_wr_req_valid_o,
    output logic                  mem_req_is_instr_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    output access_size_t          mem_access_size_o,

    input  logic                  mem_data_valid_i,
    input  logic                  mem_data_is_instr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,

    output logic                  err_o
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_if_inflight;
    logic [CNT_W-1:0] r_d_inflight;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_last_grant;
    logic             r_err;

    logic w_if_elig;
    logic w_d_elig;
    logic w_grant_if;
    logic w_grant_d;
    logic w_if_issue;
    logic w_d_issue;
    logic w_if_rsp;
    logic w_d_rsp;
    logic w_if_dec;
    logic w_d_dec;
    logic w_drop_dec;
    logic w_err_set;

    // Writes never consume read credit, so a write is eligible even at the cap.
    assign w_if_elig = if_req_valid_i & (r_if_inflight < MAX_CNT) & ~if_flush_i;
    assign w_d_elig  = d_req_valid_i & (d_req_wr_i | (r_d_inflight < MAX_CNT));

    always_comb begin
        w_grant_if = 1'b0;
        w_grant_d  = 1'b0;
        if (rst_i) begin
`ifdef MEM_ARB_RR_EN
            if (w_if_elig && w_d_elig) begin
                w_grant_if = r_last_grant;
                w_grant_d  = ~r_last_grant;
            end else begin
                w_grant_if = w_if_elig;
                w_grant_d  = w_d_elig;
            end
`else
            w_grant_d  = w_d_elig;
            w_grant_if = w_if_elig & ~w_d_elig;
`endif
        end
    end

    assign w_if_issue = w_grant_if;
    assign w_d_issue  = w_grant_d & ~d_req_wr_i;

    assign if_req_ready_o = w_grant_if;
    assign d_req_ready_o  = w_grant_d;

    always_comb begin
        mem_rd_req_valid_o = w_if_issue | w_d_issue;
        mem_wr_req_valid_o = w_grant_d & d_req_wr_i;
        mem_req_is_instr_o = w_grant_if;
        mem_wr_data_o      = d_wr_data_i;
        mem_address_o      = d_addr_i;
        mem_access_size_o  = d_access_size_i;
        if (w_grant_if) begin
            mem_address_o     = if_addr_i;
            mem_access_size_o = WORD;
        end
    end

    // A response only retires a read when its requester actually has one outstanding.
    assign w_if_rsp   = mem_data_valid_i & mem_data_is_instr_i;
    assign w_d_rsp    = mem_data_valid_i & ~mem_data_is_instr_i;
    assign w_if_dec   = w_if_rsp & (r_if_inflight != '0);
    assign w_d_dec    = w_d_rsp & (r_d_inflight != '0);
    assign w_drop_dec = w_if_dec & (r_drop_cnt != '0);
    assign w_err_set  = (w_if_rsp & (r_if_inflight == '0)) | (w_d_rsp & (r_d_inflight == '0));

    assign if_rsp_valid_o = rst_i & w_if_dec & ~w_drop_dec & ~if_flush_i;
    assign d_rsp_valid_o  = rst_i & w_d_dec;
    assign if_rsp_data_o  = mem_data_i;
    assign d_rsp_data_o   = mem_data_i;
    assign err_o          = r_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_if_inflight <= '0;
            r_d_inflight  <= '0;
            r_drop_cnt    <= '0;
            r_last_grant  <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            r_if_inflight <= r_if_inflight + CNT_W'(w_if_issue) - CNT_W'(w_if_dec);
            r_d_inflight  <= r_d_inflight + CNT_W'(w_d_issue) - CNT_W'(w_d_dec);

            // Every fetch still in flight after this cycle's response becomes stale.
            if (if_flush_i) begin
                r_drop_cnt <= r_if_inflight - CNT_W'(w_if_dec);
            end else if (w_drop_dec) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end

            if (w_grant_if) begin
                r_last_grant <= 1'b0;
            end else if (w_grant_d) begin
                r_last_grant <= 1'b1;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
